// File: rtl/core2mmio_pkg.sv
// Shared state encoding and default geometry for the core-to-MMIO bridge.
package core2mmio_pkg;

  localparam int unsigned DEF_ADDR_W  = 64;
  localparam int unsigned DEF_DATA_W  = 64;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/core2mmio_bridge.sv
// Single-outstanding bridge from a stalling core load/store port to an MMIO read/write port.
// Latency is MMIO latency + 2 cycles; the core is held via cpu_stall until DONE or ERR.
module core2mmio_bridge
  import core2mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W  = DEF_ADDR_W,
  parameter int unsigned       DATA_W  = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] BASE    = '0,
  parameter logic [ADDR_W-1:0] SIZE    = ADDR_W'(64'h1_0000),
  parameter int unsigned       TIMEOUT = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic                  cpu_ren,
  input  logic                  cpu_wen,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [DATA_W/8-1:0]   cpu_wmask,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  output logic                  cpu_err,
  output logic [ADDR_W-1:0]     mmio_raddr,
  output logic                  mmio_ren,
  input  logic [DATA_W-1:0]     mmio_rdata,
  input  logic                  mmio_rvalid,
  output logic [ADDR_W-1:0]     mmio_waddr,
  output logic                  mmio_wen,
  output logic [DATA_W-1:0]     mmio_wdata,
  output logic [DATA_W/8-1:0]   mmio_wmask,
  input  logic                  mmio_wvalid
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  // Last wait cycle: a valid seen here still completes, otherwise the access times out.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W:0]  WIN_LO   = {1'b0, BASE};
  localparam logic [ADDR_W:0]  WIN_HI   = {1'b0, BASE} + {1'b0, SIZE};

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                cpu_req;
  logic                in_range;

  assign cpu_req  = cpu_ren | cpu_wen;
  assign in_range = ({1'b0, cpu_addr} >= WIN_LO) && ({1'b0, cpu_addr} < WIN_HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (!in_range) begin
            state_d = ERR;
            if (!cpu_wen) rdata_d = '1;
          end else begin
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            wmask_d = cpu_wmask;
            cnt_d   = '0;
            state_d = cpu_wen ? WR : RD;
          end
        end
      end
      RD: begin
        if (mmio_rvalid) begin
          rdata_d = mmio_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '1;
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR: begin
        if (mmio_wvalid) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
    end
  end

  assign mmio_ren   = (state_q == RD);
  assign mmio_wen   = (state_q == WR);
  assign mmio_raddr = addr_q;
  assign mmio_waddr = addr_q;
  assign mmio_wdata = wdata_q;
  assign mmio_wmask = wmask_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_err    = (state_q == ERR);
  // Stall drops only in the one-cycle completion states, giving a bubble between accesses.
  assign cpu_stall  = cpu_req & ~((state_q == DONE) | (state_q == ERR));

endmodule

// File: tb/tb_core2mmio_bridge.sv
// Directed bench for core2mmio_bridge with BASE=0x1000, SIZE=0x100, TIMEOUT=4.
module tb_core2mmio_bridge;
  import core2mmio_pkg::*;

  localparam logic [63:0] BASE   = 64'h1000;
  localparam logic [63:0] SIZE   = 64'h100;
  localparam int          BUDGET = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic        cpu_ren = 1'b0, cpu_wen = 1'b0, cpu_stall, cpu_err;
  logic [7:0]  cpu_wmask = '0, mmio_wmask;
  logic [63:0] mmio_raddr, mmio_waddr, mmio_wdata, mmio_rdata = '0;
  logic        mmio_ren, mmio_wen, mmio_rvalid = 1'b0, mmio_wvalid = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int          r_stall, r_ren, r_wen;
  logic        r_both;
  logic [63:0] r_raddr, r_waddr, r_wdata;
  logic [7:0]  r_wmask;

  core2mmio_bridge #(
    .ADDR_W(64), .DATA_W(64), .BASE(BASE), .SIZE(SIZE), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_ren(cpu_ren), .cpu_wen(cpu_wen),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
    .mmio_raddr(mmio_raddr), .mmio_ren(mmio_ren),
    .mmio_rdata(mmio_rdata), .mmio_rvalid(mmio_rvalid),
    .mmio_waddr(mmio_waddr), .mmio_wen(mmio_wen),
    .mmio_wdata(mmio_wdata), .mmio_wmask(mmio_wmask),
    .mmio_wvalid(mmio_wvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents one request and plays the MMIO slave: valid on strobe cycle lat (0 = never).
  // Returns at the first non-stalled cycle, request still applied.
  task automatic do_access(input logic rd, input logic wr, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wmask,
                           input int lat, input logic [63:0] rdata);
    int sc;
    sc = 0; r_stall = 0; r_ren = 0; r_wen = 0; r_both = 1'b0;
    r_raddr = '0; r_waddr = '0; r_wdata = '0; r_wmask = '0;
    @(negedge clk);
    cpu_addr = addr; cpu_ren = rd; cpu_wen = wr; cpu_wdata = wdata; cpu_wmask = wmask;
    for (int k = 0; k < BUDGET; k++) begin
      mmio_rvalid = 1'b0; mmio_wvalid = 1'b0; mmio_rdata = '0;
      #1;
      if (!cpu_stall) break;
      r_stall++;
      if (mmio_ren && mmio_wen) r_both = 1'b1;
      if (mmio_ren) begin r_ren++; r_raddr = mmio_raddr; end
      if (mmio_wen) begin
        r_wen++; r_waddr = mmio_waddr; r_wdata = mmio_wdata; r_wmask = mmio_wmask;
      end
      if (mmio_ren || mmio_wen) begin
        sc++;
        if (sc == lat) begin
          mmio_rvalid = mmio_ren; mmio_wvalid = mmio_wen; mmio_rdata = rdata;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic drop_req();
    @(negedge clk);
    cpu_ren = 1'b0; cpu_wen = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_checks++; if (mmio_ren !== 1'b0) $display("FAIL rst_ren: got %b want 0", mmio_ren); else n_pass++;
    n_checks++; if (mmio_wen !== 1'b0) $display("FAIL rst_wen: got %b want 0", mmio_wen); else n_pass++;
    n_checks++; if (cpu_err !== 1'b0) $display("FAIL rst_err: got %b want 0", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'h0) $display("FAIL rst_rdata: got %h want 0", cpu_rdata); else n_pass++;
    n_checks++; if (cpu_stall !== 1'b0) $display("FAIL rst_stall_idle: got %b want 0", cpu_stall); else n_pass++;
    n_checks++; if (mmio_raddr !== 64'h0) $display("FAIL rst_raddr: got %h want 0", mmio_raddr); else n_pass++;
    cpu_ren = 1'b1; cpu_addr = BASE;
    #1;
    n_checks++; if (cpu_stall !== 1'b1) $display("FAIL rst_stall_req: got %b want 1", cpu_stall); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (mmio_ren !== 1'b0) $display("FAIL rst_hold_ren: got %b want 0", mmio_ren); else n_pass++;
    cpu_ren = 1'b0; cpu_addr = '0; rst = 1'b0;
  endtask

  task automatic test_read();
    do_access(1'b1, 1'b0, BASE + 64'h8, 64'h0, 8'h00, 3, 64'hDEAD_BEEF);
    n_checks++; if (r_stall !== 4) $display("FAIL rd_stall_cycles: got %0d want 4", r_stall); else n_pass++;
    n_checks++; if (r_ren !== 3) $display("FAIL rd_ren_cycles: got %0d want 3", r_ren); else n_pass++;
    n_checks++; if (r_wen !== 0) $display("FAIL rd_wen_cycles: got %0d want 0", r_wen); else n_pass++;
    n_checks++; if (r_raddr !== 64'h1008) $display("FAIL rd_raddr: got %h want 1008", r_raddr); else n_pass++;
    n_checks++; if (cpu_err !== 1'b0) $display("FAIL rd_err: got %b want 0", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", cpu_rdata); else n_pass++;
    drop_req(); #1;
    n_checks++; if (mmio_ren !== 1'b0) $display("FAIL rd_idle_ren: got %b want 0", mmio_ren); else n_pass++;
  endtask

  task automatic test_write();
    do_access(1'b0, 1'b1, BASE + 64'h10, 64'h1234, 8'h0F, 2, 64'h0);
    n_checks++; if (r_wen !== 2) $display("FAIL wr_wen_cycles: got %0d want 2", r_wen); else n_pass++;
    n_checks++; if (r_ren !== 0) $display("FAIL wr_ren_cycles: got %0d want 0", r_ren); else n_pass++;
    n_checks++; if (r_stall !== 3) $display("FAIL wr_stall_cycles: got %0d want 3", r_stall); else n_pass++;
    n_checks++; if (r_waddr !== 64'h1010) $display("FAIL wr_waddr: got %h want 1010", r_waddr); else n_pass++;
    n_checks++; if (r_wdata !== 64'h1234) $display("FAIL wr_wdata: got %h want 1234", r_wdata); else n_pass++;
    n_checks++; if (r_wmask !== 8'h0F) $display("FAIL wr_wmask: got %h want 0f", r_wmask); else n_pass++;
    n_checks++; if (cpu_err !== 1'b0) $display("FAIL wr_err: got %b want 0", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'hDEAD_BEEF) $display("FAIL wr_rdata_kept: got %h want deadbeef", cpu_rdata); else n_pass++;
    drop_req();
  endtask

  task automatic test_read_write_both();
    do_access(1'b1, 1'b1, BASE + 64'h20, 64'h55, 8'hFF, 1, 64'hBAD);
    n_checks++; if (r_ren !== 0) $display("FAIL both_ren_cycles: got %0d want 0", r_ren); else n_pass++;
    n_checks++; if (r_wen !== 1) $display("FAIL both_wen_cycles: got %0d want 1", r_wen); else n_pass++;
    n_checks++; if (r_both !== 1'b0) $display("FAIL both_strobes: got %b want 0", r_both); else n_pass++;
    n_checks++; if (r_wdata !== 64'h55) $display("FAIL both_wdata: got %h want 55", r_wdata); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'hDEAD_BEEF) $display("FAIL both_rdata_kept: got %h want deadbeef", cpu_rdata); else n_pass++;
    drop_req();
  endtask

  task automatic test_timeout();
    do_access(1'b0, 1'b1, BASE + 64'h28, 64'h77, 8'h01, 0, 64'h0);
    n_checks++; if (r_wen !== 4) $display("FAIL to_wr_wen_cycles: got %0d want 4", r_wen); else n_pass++;
    n_checks++; if (cpu_err !== 1'b1) $display("FAIL to_wr_err: got %b want 1", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'hDEAD_BEEF) $display("FAIL to_wr_rdata_kept: got %h want deadbeef", cpu_rdata); else n_pass++;
    drop_req();
    do_access(1'b1, 1'b0, BASE + 64'h30, 64'h0, 8'h00, 4, 64'h4444);
    n_checks++; if (r_ren !== 4) $display("FAIL to_late_ren_cycles: got %0d want 4", r_ren); else n_pass++;
    n_checks++; if (r_stall !== 5) $display("FAIL to_late_stall: got %0d want 5", r_stall); else n_pass++;
    n_checks++; if (cpu_err !== 1'b0) $display("FAIL to_late_err: got %b want 0", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'h4444) $display("FAIL to_late_rdata: got %h want 4444", cpu_rdata); else n_pass++;
    drop_req();
    do_access(1'b1, 1'b0, BASE + 64'h38, 64'h0, 8'h00, 0, 64'h0);
    n_checks++; if (r_ren !== 4) $display("FAIL to_rd_ren_cycles: got %0d want 4", r_ren); else n_pass++;
    n_checks++; if (cpu_err !== 1'b1) $display("FAIL to_rd_err: got %b want 1", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== {64{1'b1}}) $display("FAIL to_rd_rdata: got %h want all-ones", cpu_rdata); else n_pass++;
    drop_req(); #1;
    n_checks++; if (cpu_err !== 1'b0) $display("FAIL to_err_one_cycle: got %b want 0", cpu_err); else n_pass++;
  endtask

  task automatic test_range();
    do_access(1'b1, 1'b0, BASE + SIZE - 64'h8, 64'h0, 8'h00, 1, 64'hAA55);
    n_checks++; if (r_ren !== 1) $display("FAIL rng_top_ren: got %0d want 1", r_ren); else n_pass++;
    n_checks++; if (cpu_err !== 1'b0) $display("FAIL rng_top_err: got %b want 0", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'hAA55) $display("FAIL rng_top_rdata: got %h want aa55", cpu_rdata); else n_pass++;
    drop_req();
    do_access(1'b0, 1'b1, BASE - 64'h8, 64'h99, 8'hFF, 1, 64'h0);
    n_checks++; if (r_ren + r_wen !== 0) $display("FAIL rng_low_strobes: got %0d want 0", r_ren + r_wen); else n_pass++;
    n_checks++; if (r_stall !== 1) $display("FAIL rng_low_stall: got %0d want 1", r_stall); else n_pass++;
    n_checks++; if (cpu_err !== 1'b1) $display("FAIL rng_low_err: got %b want 1", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'hAA55) $display("FAIL rng_low_rdata_kept: got %h want aa55", cpu_rdata); else n_pass++;
    drop_req();
    do_access(1'b1, 1'b0, BASE + SIZE, 64'h0, 8'h00, 1, 64'h0);
    n_checks++; if (r_ren + r_wen !== 0) $display("FAIL rng_high_strobes: got %0d want 0", r_ren + r_wen); else n_pass++;
    n_checks++; if (r_stall !== 1) $display("FAIL rng_high_stall: got %0d want 1", r_stall); else n_pass++;
    n_checks++; if (cpu_err !== 1'b1) $display("FAIL rng_high_err: got %b want 1", cpu_err); else n_pass++;
    n_checks++; if (cpu_rdata !== {64{1'b1}}) $display("FAIL rng_high_rdata: got %h want all-ones", cpu_rdata); else n_pass++;
    drop_req();
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b0, BASE + 64'h48, 64'h0, 8'h00, 1, 64'h1111);
    n_checks++; if (cpu_rdata !== 64'h1111) $display("FAIL b2b_first_rdata: got %h want 1111", cpu_rdata); else n_pass++;
    do_access(1'b1, 1'b0, BASE + 64'h50, 64'h0, 8'h00, 2, 64'h2222);
    n_checks++; if (r_stall !== 3) $display("FAIL b2b_second_stall: got %0d want 3", r_stall); else n_pass++;
    n_checks++; if (r_raddr !== 64'h1050) $display("FAIL b2b_second_raddr: got %h want 1050", r_raddr); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'h2222) $display("FAIL b2b_second_rdata: got %h want 2222", cpu_rdata); else n_pass++;
    drop_req();
  endtask

  task automatic test_reset_inflight();
    int bad;
    bad = 0;
    @(negedge clk);
    cpu_addr = BASE + 64'h60; cpu_ren = 1'b1;
    @(negedge clk); #1;
    n_checks++; if (mmio_ren !== 1'b1) $display("FAIL rip_in_rd: got %b want 1", mmio_ren); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++; if (mmio_ren !== 1'b0) $display("FAIL rip_ren_async: got %b want 0", mmio_ren); else n_pass++;
    n_checks++; if (cpu_rdata !== 64'h0) $display("FAIL rip_rdata: got %h want 0", cpu_rdata); else n_pass++;
    n_checks++; if (dut.state_q !== IDLE) $display("FAIL rip_state: got %0d want %0d", dut.state_q, IDLE); else n_pass++;
    @(negedge clk);
    cpu_ren = 1'b0; rst = 1'b0; mmio_rvalid = 1'b1; mmio_rdata = 64'h5A5A;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (cpu_err !== 1'b0 || mmio_ren !== 1'b0 || cpu_rdata !== 64'h0) bad++;
      @(negedge clk);
      mmio_rvalid = 1'b0;
    end
    n_checks++; if (bad !== 0) $display("FAIL rip_no_completion: got %0d bad cycles want 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_read_write_both();
    test_timeout();
    test_range();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core2mmio_bridge.md
CORE2MMIO_BRIDGE -- requirements
Module: core2mmio_bridge

Interface
REQ-001 Parameter ADDR_W, default 64: address width of core and MMIO sides.
REQ-002 Parameter DATA_W, default 64: data width; SHALL be a multiple of 8; mask width is DATA_W/8.
REQ-003 Parameter BASE, default 64'h0: lowest decoded MMIO address.
REQ-004 Parameter SIZE, default 64'h1_0000: decoded window size in bytes.
REQ-005 Parameter TIMEOUT, default 255: maximum wait cycles for rvalid or wvalid; range 1..65535.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 cpu_addr, cpu_ren, cpu_wen, cpu_wdata, cpu_wmask  input  ADDR_W/1/1/DATA_W/DATA_W/8  core request, held stable while cpu_stall=1.
REQ-009 cpu_rdata  output  DATA_W  read response.
REQ-010 cpu_stall  output  1  core must hold its request.
REQ-011 cpu_err  output  1  one-cycle error flag, valid when cpu_stall=0.
REQ-012 mmio_raddr, mmio_ren  output  ADDR_W/1  read request.
REQ-013 mmio_rdata, mmio_rvalid  input  DATA_W/1  read response.
REQ-014 mmio_waddr, mmio_wen, mmio_wdata, mmio_wmask  output  ADDR_W/1/DATA_W/DATA_W/8  write request.
REQ-015 mmio_wvalid  input  1  write completion.

Function
REQ-016 FSM states: IDLE, RD, WR, DONE, ERR.
REQ-017 IDLE transitions, by first matching condition:
- no request: stay in IDLE.
- cpu_addr outside [BASE, BASE+SIZE): go to ERR; no MMIO strobe is issued.
- cpu_wen=1: latch the request and go to WR; this applies also when cpu_ren=1.
- otherwise, cpu_ren=1: latch the request and go to RD.
REQ-018 In RD, mmio_ren=1 and mmio_raddr equals the latched address. On mmio_rvalid=1, capture mmio_rdata into cpu_rdata and go to DONE.
REQ-019 In WR, mmio_wen=1 and mmio_waddr/wdata/wmask equal the latched values. On mmio_wvalid=1, go to DONE.
REQ-020 mmio_ren and mmio_wen SHALL be 0 in every state except RD and WR respectively, and SHALL never both be 1.
REQ-021 The wait counter clears on entry to RD or WR and increments each cycle valid is low. When it reaches TIMEOUT, go to ERR; cpu_rdata becomes all-ones.
REQ-022 DONE and ERR each last exactly one cycle, then go to IDLE. cpu_err=1 only in ERR.
REQ-023 cpu_stall = (cpu_ren|cpu_wen) & state∉{DONE,ERR}, combinational. This gives latency = MMIO latency + 2 cycles, and one idle bubble between back-to-back accesses.
REQ-024 A valid arriving in the same cycle the counter reaches TIMEOUT SHALL win: go to DONE, not ERR.
REQ-025 cpu_rdata holds its last captured value until the next read completion or read error. Write completions and out-of-range writes SHALL NOT alter it.
REQ-026 Address range arithmetic is performed at ADDR_W+1 bits, so BASE+SIZE never wraps.
REQ-027 In ERR, an erroring write leaves cpu_rdata unchanged; an erroring read sets cpu_rdata to all-ones.

Reset
REQ-028 rst=1 immediately forces:
- state=IDLE;
- wait counter=0;
- cpu_rdata=0;
- all latched request registers=0.
REQ-029 Consequently mmio_ren=mmio_wen=0 and cpu_err=0 asynchronously. cpu_stall follows REQ-023.
REQ-030 An access in flight when reset is asserted is abandoned; no completion or error is reported for it.

Structure
REQ-031 Package core2mmio_pkg SHALL hold the state enum (IDLE, RD, WR, DONE, ERR) and the default values of ADDR_W, DATA_W and TIMEOUT.
REQ-032 The block is a single module with no sub-modules; the wait counter is inline, with width $clog2(TIMEOUT+1).

Verification
REQ-033 Read at BASE+8, rvalid 3 cycles after mmio_ren rises, rdata=64'hDEAD_BEEF -> cpu_stall high 4 cycles, then cpu_rdata=64'hDEAD_BEEF with cpu_err=0.
REQ-034 Write at BASE+0x10, wdata=64'h1234, wmask=8'h0F, wvalid 1 cycle late -> mmio_wen high 2 cycles with exact latched values; cpu_rdata unchanged.
REQ-035 cpu_ren=cpu_wen=1 -> only mmio_wen asserts; no mmio_ren for that access.
REQ-036 Read at BASE+SIZE -> no MMIO strobe; ERR reached in 1 cycle; cpu_err=1 and cpu_rdata=all-ones.
REQ-037 TIMEOUT=4, rvalid never arrives -> ERR after 4 wait cycles; a second run with rvalid on the 4th wait cycle -> DONE.
REQ-038 rst pulsed while in RD -> mmio_ren drops without waiting for a clock edge; cpu_rdata=0; FSM is in IDLE.
